// File: rtl/dual_stream_aligner.sv
// -----------------------------------------------------------------------------
// dual_stream_aligner
//
// Purpose:
//   Takes the heads of the two per-camera stream FIFOs, which have already
//   crossed into the system clock domain. It frame-aligns the two streams on a
//   common start-of-frame and emits one paired pixel per beat, with the row and
//   column of the pair and frame markers. If the two streams fall out of
//   alignment, the block detects this, counts it, and re-seeks the next common
//   start-of-frame.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   in_pixel_i[n]    head pixel of channel FIFO n
//   in_sof_i[n]      head pixel of channel n is first pixel of a frame
//   in_valid_i[n]    head of channel n valid
//   in_ready_o[n]    pop head of channel n this cycle
//   out_pixels_o     {ch1, ch0} pixel pair
//   out_row_o        row of the pair
//   out_col_o        column of the pair
//   out_sof_o        pair is at (0,0)
//   out_eof_o        pair is at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1)
//   out_valid_o      output beat valid
//   out_ready_i      downstream accepts the beat
//   locked_o         aligner is streaming aligned pairs
//   frame_count_o    completed frames, saturating
//   resync_count_o   alignment losses, saturating
//
// Build option:
//   DUAL_STREAM_ALIGNER_STATS_EN
//     Defined:   frame_count_o and resync_count_o are implemented.
//     Undefined: the counters are removed and both ports read 0.
// -----------------------------------------------------------------------------
module dual_stream_aligner #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIXEL_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PIXEL_W-1:0]   in_pixel_i [2],
  input  logic [1:0]           in_sof_i,
  input  logic [1:0]           in_valid_i,
  output logic [1:0]           in_ready_o,
  output logic [2*PIXEL_W-1:0] out_pixels_o,
  output logic [15:0]          out_row_o,
  output logic [15:0]          out_col_o,
  output logic                 out_sof_o,
  output logic                 out_eof_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 locked_o,
  output logic [15:0]          frame_count_o,
  output logic [15:0]          resync_count_o
);

  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic {
    ST_SEEK   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t               r_state;
  logic [15:0]          r_row;        // position of the next pair to be popped
  logic [15:0]          r_col;
  logic [2*PIXEL_W-1:0] r_out_pixels;
  logic [15:0]          r_out_row;
  logic [15:0]          r_out_col;
  logic                 r_out_sof;
  logic                 r_out_eof;
  logic                 r_out_valid;

  logic w_slot_free;
  logic w_both_valid;
  logic w_origin;
  logic w_last_col;
  logic w_last_row;
  logic w_sof_ok;
  logic w_fire;
  logic w_violation;

  // The output slot can take a new pair if it is empty or is draining this cycle.
  assign w_slot_free  = !r_out_valid || out_ready_i;
  assign w_both_valid = in_valid_i[0] && in_valid_i[1];
  assign w_origin     = (r_row == 16'd0) && (r_col == 16'd0);
  assign w_last_col   = (r_col == LAST_COL);
  assign w_last_row   = (r_row == LAST_ROW);

  // At the origin both heads must carry sof. Everywhere else neither head may.
  assign w_sof_ok    = w_origin ? (in_sof_i == 2'b11) : (in_sof_i == 2'b00);
  assign w_fire      = (r_state == ST_STREAM) && w_both_valid && w_slot_free && w_sof_ok;
  assign w_violation = (r_state == ST_STREAM) && w_both_valid && w_slot_free && !w_sof_ok;

  // Ready is gated by reset so that no head is popped during the reset cycle.
  // While seeking, each channel drops non-sof heads on its own.
  // While streaming, both channels are popped together or not at all.
  always_comb begin
    in_ready_o = 2'b00;
    if (!rst_i) begin
      if (r_state == ST_SEEK) begin
        in_ready_o = in_valid_i & ~in_sof_i;
      end else if (w_fire) begin
        in_ready_o = 2'b11;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_SEEK;
      r_row        <= '0;
      r_col        <= '0;
      r_out_pixels <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      // A beat that has been accepted leaves the slot. A fire below refills it.
      // A beat that is still pending survives a drop back to SEEK.
      if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_SEEK: begin
          if (w_both_valid && (in_sof_i == 2'b11)) begin
            r_state <= ST_STREAM;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_STREAM: begin
          if (w_fire) begin
            r_out_pixels <= {in_pixel_i[1], in_pixel_i[0]};
            r_out_row    <= r_row;
            r_out_col    <= r_col;
            r_out_sof    <= w_origin;
            r_out_eof    <= w_last_col && w_last_row;
            r_out_valid  <= 1'b1;
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last_row ? 16'd0 : r_row + 16'd1;
            end else begin
              r_col <= r_col + 16'd1;
            end
          end else if (w_violation) begin
            // Abandon the partial frame. The offending heads stay put, and
            // SEEK then decides which of them to keep.
            r_state <= ST_SEEK;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        default: r_state <= ST_SEEK;
      endcase
    end
  end

`ifdef DUAL_STREAM_ALIGNER_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_resync_count;
  logic        w_frame_done;

  assign w_frame_done = w_fire && w_last_col && w_last_row;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_count  <= '0;
      r_resync_count <= '0;
    end else begin
      if (w_frame_done && (r_frame_count != 16'hFFFF)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_violation && (r_resync_count != 16'hFFFF)) begin
        r_resync_count <= r_resync_count + 16'd1;
      end
    end
  end

  assign frame_count_o  = r_frame_count;
  assign resync_count_o = r_resync_count;
`else
  assign frame_count_o  = '0;
  assign resync_count_o = '0;
`endif

  assign out_pixels_o = r_out_pixels;
  assign out_row_o    = r_out_row;
  assign out_col_o    = r_out_col;
  assign out_sof_o    = r_out_sof;
  assign out_eof_o    = r_out_eof;
  assign out_valid_o  = r_out_valid;
  assign locked_o     = (r_state == ST_STREAM);

endmodule

// File: tb/tb_dual_stream_aligner.sv
// -----------------------------------------------------------------------------
// tb_dual_stream_aligner
//
// Purpose:
//   Self-checking bench for dual_stream_aligner with a 4x2 image.
//   - Each channel FIFO is a queue of {sof, pixel} items.
//   - A reference model walks the two queues and produces the expected beats,
//     the frame and resync counts, and the final lock state. It does this
//     independently of timing, because the aligner's output sequence depends
//     only on the item order.
//   - Valid and ready handshakes are randomized around that model.
// -----------------------------------------------------------------------------
module tb_dual_stream_aligner;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [PW-1:0]   in_px [2];
  logic [1:0]      in_sof;
  logic [1:0]      in_vld;
  logic [1:0]      in_rdy;
  logic [2*PW-1:0] out_px;
  logic [15:0]     out_row;
  logic [15:0]     out_col;
  logic            out_sof;
  logic            out_eof;
  logic            out_vld;
  logic            out_rdy;
  logic            locked;
  logic [15:0]     frames;
  logic [15:0]     resyncs;

  always #5 clk = ~clk;

  dual_stream_aligner #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_W     (PW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_pixel_i    (in_px),
    .in_sof_i      (in_sof),
    .in_valid_i    (in_vld),
    .in_ready_o    (in_rdy),
    .out_pixels_o  (out_px),
    .out_row_o     (out_row),
    .out_col_o     (out_col),
    .out_sof_o     (out_sof),
    .out_eof_o     (out_eof),
    .out_valid_o   (out_vld),
    .out_ready_i   (out_rdy),
    .locked_o      (locked),
    .frame_count_o (frames),
    .resync_count_o(resyncs)
  );

  typedef struct packed {
    logic          sof;
    logic [PW-1:0] px;
  } item_t;

  item_t       q0[$];
  item_t       q1[$];
  logic [49:0] exp_q[$];
  int          exp_frames;
  int          exp_resyncs;
  bit          exp_locked;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          cfg_v0, cfg_v1, cfg_rd, cfg_rlow_start, cfg_rlow_len;
  bit          cfg_toggle;
  int          cyc;
  bit          full;
  bit          prev_stall;
  logic [49:0] prev_beat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [49:0] cur_beat();
    return {out_px, out_row, out_col, out_sof, out_eof};
  endfunction

  task automatic push_item(input int ch, input item_t it);
    if (ch == 0) q0.push_back(it);
    else         q1.push_back(it);
  endtask

  task automatic push_frame(input int ch, input int len, input bit rnd);
    item_t it;
    for (int k = 0; k < len; k++) begin
      it.sof = (k == 0);
      it.px  = rnd ? PW'($urandom) : PW'(k);
      push_item(ch, it);
    end
  endtask

  task automatic push_garbage(input int ch, input int n);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.sof = 1'b0;
      it.px  = PW'(224 + k);
      push_item(ch, it);
    end
  endtask

  // Reference model. It walks both item lists using the alignment rules:
  // - SEEK: drop non-sof heads; a pair of sof heads starts a frame.
  // - STREAM: sof is expected on both heads exactly at (0,0); any other
  //   pattern is a resync.
  task automatic model_run();
    int i0, i1, row, col;
    bit seek, origin, last, ok;
    i0 = 0; i1 = 0; row = 0; col = 0; seek = 1;
    exp_q.delete();
    exp_frames = 0;
    exp_resyncs = 0;
    while (i0 < q0.size() && i1 < q1.size()) begin
      if (seek) begin
        if (!q0[i0].sof)      i0++;
        else if (!q1[i1].sof) i1++;
        else begin
          seek = 0; row = 0; col = 0;
        end
      end else begin
        origin = (row == 0) && (col == 0);
        last   = (row == H - 1) && (col == W - 1);
        ok = origin ? (q0[i0].sof && q1[i1].sof) : (!q0[i0].sof && !q1[i1].sof);
        if (!ok) begin
          seek = 1;
          exp_resyncs++;
        end else begin
          exp_q.push_back({q1[i1].px, q0[i0].px, 16'(row), 16'(col), origin, last});
          i0++; i1++;
          if (last) exp_frames++;
          col++;
          if (col == W) begin
            col = 0;
            row++;
            if (row == H) row = 0;
          end
        end
      end
    end
    exp_locked = !seek;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_vld   = 2'b00;
    in_sof   = 2'b00;
    in_px[0] = '0;
    in_px[1] = '0;
    out_rdy  = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    prev_stall = 0;
    cyc        = 0;
    full       = 0;
  endtask

  task automatic one_cycle();
    bit          en0, en1, p0, p1;
    logic [49:0] exp_beat;
    en0 = full || ($urandom_range(0, 99) < cfg_v0);
    if (full)            en1 = 1;
    else if (cfg_toggle) en1 = cyc[0];
    else                 en1 = ($urandom_range(0, 99) < cfg_v1);
    if (en0 && q0.size() > 0) begin
      in_vld[0] = 1'b1; in_sof[0] = q0[0].sof; in_px[0] = q0[0].px;
    end else begin
      in_vld[0] = 1'b0; in_sof[0] = 1'($urandom); in_px[0] = PW'($urandom);
    end
    if (en1 && q1.size() > 0) begin
      in_vld[1] = 1'b1; in_sof[1] = q1[0].sof; in_px[1] = q1[0].px;
    end else begin
      in_vld[1] = 1'b0; in_sof[1] = 1'($urandom); in_px[1] = PW'($urandom);
    end
    out_rdy = full || (((cyc < cfg_rlow_start) || (cyc >= cfg_rlow_start + cfg_rlow_len))
                       && ($urandom_range(0, 99) < cfg_rd));

    @(negedge clk);
    if (prev_stall) check_eq("hold", {out_vld, cur_beat()}, {1'b1, prev_beat});
    if (locked) check_eq("pair_ready", in_rdy[0], in_rdy[1]);
    if (locked && out_vld && !out_rdy) check_eq("stall_no_pop", in_rdy, 2'b00);
`ifndef DUAL_STREAM_ALIGNER_STATS_EN
    check_eq("stats_zero", {frames, resyncs}, 32'd0);
`endif
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", out_vld, 1'b0);
      end else begin
        exp_beat = exp_q.pop_front();
        $display("beat row=%0d col=%0d px=%h sof=%0b eof=%0b", out_row, out_col, out_px, out_sof, out_eof);
        check_eq("beat", cur_beat(), exp_beat);
      end
    end
    prev_stall = out_vld && !out_rdy;
    prev_beat  = cur_beat();
    p0 = in_vld[0] && in_rdy[0];
    p1 = in_vld[1] && in_rdy[1];
    @(posedge clk);
    #1;
    if (p0) q0.delete(0);
    if (p1) q1.delete(0);
    cyc++;
  endtask

  task automatic run_scenario(input string name, input int v0, input int v1, input int rd,
                              input bit toggle, input int rls, input int rll);
    do_reset();
    cfg_v0 = v0; cfg_v1 = v1; cfg_rd = rd; cfg_toggle = toggle;
    cfg_rlow_start = rls; cfg_rlow_len = rll;
    model_run();
    while (exp_q.size() > 0 && cyc < 3000) one_cycle();
    check_eq({name, "_drained"}, exp_q.size(), 0);
    full = 1;
    repeat (40) one_cycle();
`ifdef DUAL_STREAM_ALIGNER_STATS_EN
    check_eq({name, "_frames"}, frames, exp_frames);
    check_eq({name, "_resyncs"}, resyncs, exp_resyncs);
`else
    check_eq({name, "_frames"}, frames, 0);
    check_eq({name, "_resyncs"}, resyncs, 0);
`endif
    check_eq({name, "_locked"}, locked, exp_locked);
    $display("scenario %s cycles=%0d frames=%0d resyncs=%0d", name, cyc, exp_frames, exp_resyncs);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check_eq("reset_state",
             {out_vld, out_sof, out_eof, out_px, out_row, out_col, locked, in_rdy, frames, resyncs}, 0);

    // Aligned single frame at full rate
    push_frame(0, 8, 0);
    push_frame(1, 8, 0);
    run_scenario("aligned", 100, 100, 100, 0, 0, 0);

    // Channel 1 preceded by three garbage pixels
    push_frame(0, 8, 0);
    push_garbage(1, 3);
    push_frame(1, 8, 0);
    run_scenario("garbage", 100, 100, 100, 0, 0, 0);

    // Channel 0 restarts a frame at its fifth pixel
    push_frame(0, 4, 0);
    push_frame(0, 8, 0);
    push_frame(1, 8, 0);
    push_frame(1, 8, 0);
    run_scenario("inject", 100, 100, 100, 0, 0, 0);

    // Downstream stall of five cycles in the middle of a frame
    push_frame(0, 8, 0);
    push_frame(0, 8, 0);
    push_frame(1, 8, 0);
    push_frame(1, 8, 0);
    run_scenario("stall", 100, 100, 100, 0, 4, 5);

    // Channel 1 valid toggling every other cycle
    push_frame(0, 8, 1);
    push_frame(0, 8, 1);
    push_frame(1, 8, 1);
    push_frame(1, 8, 1);
    run_scenario("toggle", 100, 100, 100, 1, 0, 0);

    // Random frames with garbage and truncation, random handshakes
    for (int f = 0; f < 10; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 99) < 25) push_garbage(ch, $urandom_range(1, 3));
        push_frame(ch, ($urandom_range(0, 99) < 15) ? $urandom_range(1, 7) : 8, 1);
      end
    end
    run_scenario("random", 70, 60, 70, 0, 0, 0);

    // Reset asserted mid-frame while a beat is held in the output register
    do_reset();
    push_frame(0, 8, 0);
    push_frame(1, 8, 0);
    cfg_v0 = 100; cfg_v1 = 100; cfg_rd = 100; cfg_toggle = 0;
    cfg_rlow_start = 0; cfg_rlow_len = 0;
    model_run();
    repeat (6) one_cycle();
    check_eq("pre_rst_valid", out_vld, 1'b1);
    rst    = 1'b1;
    in_vld = 2'b11;
    in_sof = 2'b00;
    #1;
    check_eq("rst_ready_gated", in_rdy, 2'b00);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    in_vld = 2'b00;
    #1;
    check_eq("rst_outs", {out_vld, out_sof, out_eof, out_px, out_row, out_col, locked, in_rdy}, 0);
    check_eq("rst_stats", {frames, resyncs}, 32'd0);
    q0.delete();
    q1.delete();
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
